// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: collects slot-serial words into holding
// registers and publishes all four channels together when a frame completes.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       slot_q;
    logic [WIDTH-1:0] hold0_q;
    logic [WIDTH-1:0] hold1_q;
    logic [WIDTH-1:0] hold2_q;
    logic [WIDTH-1:0] ch0_q;
    logic [WIDTH-1:0] ch1_q;
    logic [WIDTH-1:0] ch2_q;
    logic [WIDTH-1:0] ch3_q;
    logic             frame_valid_q;
    logic             sync_err_q;

    // Framing FSM, slot counter, holding registers and published channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            slot_q        <= 2'd0;
            hold0_q       <= '0;
            hold1_q       <= '0;
            hold2_q       <= '0;
            ch0_q         <= '0;
            ch1_q         <= '0;
            ch2_q         <= '0;
            ch3_q         <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        if (frame_sync) begin
                            hold0_q <= din;
                            slot_q  <= 2'd1;
                            state_q <= ST_LOCKED;
                        end else begin
                            slot_q  <= 2'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (frame_sync) begin
                            // A sync anywhere but slot 0 aborts the partial frame and restarts.
                            sync_err_q <= (slot_q != 2'd0);
                            hold0_q    <= din;
                            slot_q     <= 2'd1;
                        end else begin
                            case (slot_q)
                                2'd0: begin
                                    sync_err_q <= 1'b1;
                                    slot_q     <= 2'd0;
                                    state_q    <= ST_HUNT;
                                end
                                2'd1: begin
                                    hold1_q <= din;
                                    slot_q  <= 2'd2;
                                end
                                2'd2: begin
                                    hold2_q <= din;
                                    slot_q  <= 2'd3;
                                end
                                2'd3: begin
                                    ch0_q         <= hold0_q;
                                    ch1_q         <= hold1_q;
                                    ch2_q         <= hold2_q;
                                    ch3_q         <= din;
                                    frame_valid_q <= 1'b1;
                                    slot_q        <= 2'd0;
                                end
                                default: begin
                                    slot_q  <= 2'd0;
                                    state_q <= ST_HUNT;
                                end
                            endcase
                        end
                    end
                    default: begin
                        slot_q  <= 2'd0;
                        state_q <= ST_HUNT;
                    end
                endcase
            end else begin
                slot_q <= slot_q;
            end
        end
    end

    assign ch0         = ch0_q;
    assign ch1         = ch1_q;
    assign ch2         = ch2_q;
    assign ch3         = ch3_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_q;
    assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based frame model.
module tb_tdm_demux_4ch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame under construction is simply a queue of words.
    logic [W-1:0] m_q[$];
    logic         m_locked;
    logic [W-1:0] m_ch[4];
    logic         m_fv;
    logic         m_err;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         s;
        logic [36:0]  exp;
    } vec_t;

    vec_t tbl[13];

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_valid(frame_valid), .slot(slot), .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] pack(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2, input logic [7:0] c3,
                                         input logic fv, input logic er,
                                         input logic [1:0] sl, input logic lk);
        return {c0, c1, c2, c3, fv, er, sl, lk};
    endfunction

    function automatic logic [36:0] dut_out();
        return pack(ch0, ch1, ch2, ch3, frame_valid, sync_err, slot, locked);
    endfunction

    function automatic logic [36:0] model_out();
        return pack(m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_fv, m_err,
                    2'(m_q.size()), m_locked);
    endfunction

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (ch0..3|fv|err|slot|locked)", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_locked = 1'b0;
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] d, input logic v, input logic s);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_q = {d};
                    m_locked = 1'b1;
                end
            end else if (s) begin
                if (m_q.size() != 0) m_err = 1'b1;
                m_q = {d};
            end else if (m_q.size() == 0) begin
                m_err = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_ch[i] = m_q[i];
                    m_fv = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic v, input logic s);
        @(negedge clk);
        din = d;
        din_valid = v;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [W-1:0] d, input logic v, input logic s);
        drive(d, v, s);
        model_step(d, v, s);
        check(name, dut_out(), model_out());
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        model_reset();

        tbl[0]  = '{8'h11, 1'b1, 1'b1, pack(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1, 1'b1)};
        tbl[1]  = '{8'h22, 1'b1, 1'b0, pack(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1)};
        tbl[2]  = '{8'h33, 1'b1, 1'b0, pack(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1)};
        tbl[3]  = '{8'h44, 1'b1, 1'b0, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 2'd0, 1'b1)};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 2'd0, 1'b1)};
        tbl[5]  = '{8'h99, 1'b0, 1'b1, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 2'd0, 1'b1)};
        tbl[6]  = '{8'h01, 1'b1, 1'b1, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 2'd1, 1'b1)};
        tbl[7]  = '{8'h02, 1'b1, 1'b0, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 2'd2, 1'b1)};
        tbl[8]  = '{8'h55, 1'b1, 1'b1, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 2'd1, 1'b1)};
        tbl[9]  = '{8'h66, 1'b1, 1'b0, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 2'd2, 1'b1)};
        tbl[10] = '{8'h77, 1'b1, 1'b0, pack(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 2'd3, 1'b1)};
        tbl[11] = '{8'h88, 1'b1, 1'b0, pack(8'h55, 8'h66, 8'h77, 8'h88, 1'b1, 1'b0, 2'd0, 1'b1)};
        tbl[12] = '{8'h00, 1'b0, 1'b0, pack(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 1'b0, 2'd0, 1'b1)};

        #12;
        check("reset_state", dut_out(), pack(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].s);
            model_step(tbl[i].d, tbl[i].v, tbl[i].s);
            check($sformatf("table_%0d", i), dut_out(), tbl[i].exp);
        end

        // Back-to-back frames with din_valid held high.
        step("b2b_A0", 8'hA0, 1'b1, 1'b1);
        step("b2b_A1", 8'hA1, 1'b1, 1'b0);
        step("b2b_A2", 8'hA2, 1'b1, 1'b0);
        step("b2b_A3", 8'hA3, 1'b1, 1'b0);
        step("b2b_B0", 8'hB0, 1'b1, 1'b1);
        step("b2b_B1", 8'hB1, 1'b1, 1'b0);
        step("b2b_B2", 8'hB2, 1'b1, 1'b0);
        step("b2b_B3", 8'hB3, 1'b1, 1'b0);
        check("b2b_final", dut_out(), pack(8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1, 1'b0, 2'd0, 1'b1));

        // Frame with 3-cycle gaps between words.
        for (int w = 0; w < 4; w++) begin
            step("gap_word", 8'hA1 + 8'(w), 1'b1, (w == 0));
            if (w < 3) begin
                for (int g = 0; g < 3; g++) step("gap_idle", 8'($urandom), 1'b0, 1'($urandom));
            end
        end
        check("gap_final", dut_out(), pack(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1, 1'b0, 2'd0, 1'b1));

        // Missing sync at slot 0 drops lock; non-sync words then ignored.
        step("miss_sync", 8'h5A, 1'b1, 1'b0);
        check("miss_sync_abs", dut_out(), pack(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b0, 1'b1, 2'd0, 1'b0));
        step("hunt_ign0", 8'h5B, 1'b1, 1'b0);
        step("hunt_ign1", 8'h5C, 1'b1, 1'b0);
        step("hunt_sync", 8'hD0, 1'b1, 1'b1);

        // Asynchronous reset two words into a frame.
        step("ar_w0", 8'hE1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset", dut_out(), pack(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0));
        rst = 1'b0;
        step("post_C0", 8'hC0, 1'b1, 1'b1);
        step("post_C1", 8'hC1, 1'b1, 1'b0);
        step("post_C2", 8'hC2, 1'b1, 1'b0);
        step("post_C3", 8'hC3, 1'b1, 1'b0);
        check("post_reset_frame", dut_out(), pack(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b0, 2'd0, 1'b1));

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step("random", 8'($urandom), ($urandom_range(9, 0) < 7), ($urandom_range(3, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
